// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU compare path.
package alu_pkg;

  // Compare opcode; the 2-bit encoding is fully decoded, so no illegal values exist.
  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_NE = 2'd1,
    CMP_LT = 2'd2,
    CMP_GT = 2'd3
  } cmp_op_t;

  localparam int ALU_WIDTH = 6;

endpackage

// File: rtl/alu_cmp_fifo.sv
// Small first-word-fall-through result FIFO for the compare stream.
// The head is read combinationally so a result is visible the cycle after it is pushed.
module alu_cmp_fifo
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
)
(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             full;
  logic             push_en;
  logic             pop_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);

  // A push into a full FIFO is only taken when the head leaves in the same cycle;
  // a pop on an empty FIFO is ignored.
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  // Occupancy bookkeeping; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Storage array; contents need no reset because the head is only trusted when not empty.
  always_ff @(posedge clock) begin
    if (push_en) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/alu_cmp_stream.sv
// Streaming compare engine: registers one EQ/NE/LT/GT result per accepted request,
// buffers results in a FIFO, and counts true results for debug.
module alu_cmp_stream
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
)
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] true_count,
  input  logic             clear_count
);

  localparam int AW = $clog2(DEPTH);

  logic             cmp_true;
  logic             accept;
  logic             pop;
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_res_reg;
  logic [AW:0]      fifo_count;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic [AW+1:0]    occupancy;
  logic [CNT_W-1:0] true_count_reg;

  // Unsigned compare of the presented operands, selected by opcode.
  always_comb begin
    cmp_true = 1'b0;
    case (cmp_op_t'(in_op))
      CMP_EQ:  cmp_true = (A == B);
      CMP_NE:  cmp_true = (A != B);
      CMP_LT:  cmp_true = (A < B);
      CMP_GT:  cmp_true = (A > B);
      default: cmp_true = 1'b0;
    endcase
  end

  // Credit check counts the result in flight in stage 1 so its FIFO push can never
  // overflow; it depends on registers only.
  assign occupancy = {1'b0, fifo_count} + (AW+2)'(s1_valid_reg);
  assign in_ready  = (occupancy < (AW+2)'(DEPTH));
  assign accept    = in_valid && in_ready;

  // Stage 1: capture the zero-extended compare result of an accepted request.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_res_reg   <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) s1_res_reg <= WIDTH'(cmp_true);
    end
  end

  alu_cmp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (s1_valid_reg),
    .push_data (s1_res_reg),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign result    = fifo_empty ? '0 : fifo_head;

  // Saturating count of true results entering the FIFO; clear wins over increment.
  always_ff @(posedge clock) begin
    if (!reset_n || clear_count) begin
      true_count_reg <= '0;
    end else if (s1_valid_reg && s1_res_reg[0] && (true_count_reg != '1)) begin
      true_count_reg <= true_count_reg + CNT_W'(1);
    end
  end

  assign true_count = true_count_reg;

endmodule

// File: tb/tb_alu_cmp_stream.sv
// Directed bench for alu_cmp_stream: table of single compares plus hand-written
// back-to-back, backpressure, reset-flush and counter-saturation sequences.
module tb_alu_cmp_stream;
  import alu_pkg::*;

  localparam int WIDTH = 6;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] true_count;
  logic             clear_count;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops_seq = 0;
  int first_pop = 0;
  int last_pop = 0;
  int exp_true = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             cur_exp;

  always #5 clock = ~clock;

  alu_cmp_stream #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .true_count  (true_count),
    .clear_count (clear_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_op    = v.op;
    A        = v.a;
    B        = v.b;
    in_valid = 1'b1;
    cur_exp  = v.exp;
  endtask

  // One clock: score a pop and record an accept using pre-edge values, then advance.
  task automatic cycle();
    logic [WIDTH-1:0] want;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_result", 32'(exp_q.size()), 32'd1);
      end else begin
        want = exp_q.pop_front();
        check("result_order", 32'(result), 32'(want));
      end
      $display("t=%0t result popped = %0d", $time, result);
      if (pops_seq == 0) first_pop = cyc;
      last_pop = cyc;
      pops_seq++;
    end
    if (in_valid && in_ready) exp_q.push_back(WIDTH'(cur_exp));
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 40) begin
      cycle();
      g++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[10];
    vec_t bb[4];
    vec_t bp[6];
    vec_t t1;
    int   k;
    int   g;
    int   n;
    logic acc;

    vecs[0] = '{CMP_EQ, 6'd11, 6'd11, 1'b1};
    vecs[1] = '{CMP_EQ, 6'd12, 6'd14, 1'b0};
    vecs[2] = '{CMP_NE, 6'd12, 6'd14, 1'b1};
    vecs[3] = '{CMP_LT, 6'd3,  6'd5,  1'b1};
    vecs[4] = '{CMP_GT, 6'd3,  6'd5,  1'b0};
    vecs[5] = '{CMP_LT, 6'd63, 6'd0,  1'b0};
    vecs[6] = '{CMP_GT, 6'd63, 6'd0,  1'b1};
    vecs[7] = '{CMP_EQ, 6'd0,  6'd0,  1'b1};
    vecs[8] = '{CMP_NE, 6'd7,  6'd7,  1'b0};
    vecs[9] = '{CMP_LT, 6'd0,  6'd63, 1'b1};

    bb[0] = '{CMP_NE, 6'd12, 6'd14, 1'b1};
    bb[1] = '{CMP_LT, 6'd3,  6'd5,  1'b1};
    bb[2] = '{CMP_GT, 6'd3,  6'd5,  1'b0};
    bb[3] = '{CMP_LT, 6'd63, 6'd0,  1'b0};

    bp[0] = '{CMP_EQ, 6'd1,  6'd1,  1'b1};
    bp[1] = '{CMP_NE, 6'd1,  6'd1,  1'b0};
    bp[2] = '{CMP_LT, 6'd1,  6'd2,  1'b1};
    bp[3] = '{CMP_GT, 6'd1,  6'd2,  1'b0};
    bp[4] = '{CMP_GT, 6'd40, 6'd39, 1'b1};
    bp[5] = '{CMP_LT, 6'd40, 6'd39, 1'b0};

    t1 = '{CMP_EQ, 6'd9, 6'd9, 1'b1};

    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_op       = 2'd0;
    A           = '0;
    B           = '0;
    out_ready   = 1'b0;
    clear_count = 1'b0;
    cur_exp     = 1'b0;

    // Reset for two edges.
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_result",     32'(result),     32'd0);
    check("rst_true_count", 32'(true_count), 32'd0);

    // Single compares: exact two-edge latency, then the pop empties the FIFO.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      check("vec_in_ready", 32'(in_ready), 32'd1);
      cycle();
      in_valid = 1'b0;
      check("vec_latency_early", 32'(out_valid), 32'd0);
      cycle();
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_result", 32'(result), 32'(vecs[i].exp));
      if (vecs[i].exp) exp_true++;
      check("vec_true_count", 32'(true_count), 32'(exp_true));
      cycle();
      check("vec_empty_after_pop", 32'(out_valid), 32'd0);
      check("vec_result_zero", 32'(result), 32'd0);
    end

    // Back-to-back stream: one result per cycle in order.
    pops_seq = 0;
    for (int j = 0; j < 4; j++) begin
      drive(bb[j]);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      cycle();
    end
    in_valid = 1'b0;
    drain("b2b_drain");
    check("b2b_pops", 32'(pops_seq), 32'd4);
    check("b2b_spacing", 32'(last_pop - first_pop), 32'd3);
    exp_true += 2;
    check("b2b_true_count", 32'(true_count), 32'(exp_true));

    // Backpressure: credit closes after four accepts, head holds, then all drain.
    out_ready = 1'b0;
    pops_seq = 0;
    for (int j = 0; j < 4; j++) begin
      drive(bp[j]);
      check("bp_ready_before_full", 32'(in_ready), 32'd1);
      cycle();
    end
    drive(bp[4]);
    check("bp_ready_full", 32'(in_ready), 32'd0);
    cycle();
    check("bp_ready_still_full", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head_hold", 32'(result), 32'(bp[0].exp));
    check("bp_true_count_partial", 32'(true_count), 32'(exp_true + 2));
    cycle();
    check("bp_head_hold2", 32'(result), 32'(bp[0].exp));
    out_ready = 1'b1;
    k = 4;
    g = 0;
    while (k < 6 && g < 20) begin
      drive(bp[k]);
      acc = in_valid && in_ready;
      cycle();
      if (acc) k++;
      g++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 32'(k), 32'd6);
    drain("bp_drain");
    check("bp_pops", 32'(pops_seq), 32'd6);
    exp_true += 3;
    check("bp_true_count", 32'(true_count), 32'(exp_true));

    // Reset with FIFO holding three and stage 1 valid: everything is discarded.
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(t1);
      cycle();
    end
    in_valid = 1'b0;
    check("pre_reset_full", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
    check("flush_out_valid",  32'(out_valid),  32'd0);
    check("flush_result",     32'(result),     32'd0);
    check("flush_true_count", 32'(true_count), 32'd0);
    check("flush_in_ready",   32'(in_ready),   32'd1);
    exp_q.delete();
    exp_true = 0;
    reset_n = 1'b1;
    out_ready = 1'b1;
    pops_seq = 0;
    repeat (5) cycle();
    check("flush_no_output", 32'(pops_seq), 32'd0);

    // Saturation: 255 true results, one more holds, then clear beats an increment.
    out_ready = 1'b1;
    n = 0;
    g = 0;
    drive(t1);
    while (n < 255 && g < 400) begin
      acc = in_valid && in_ready;
      cycle();
      if (acc) n++;
      g++;
    end
    in_valid = 1'b0;
    check("sat_accepts", 32'(n), 32'd255);
    drain("sat_drain");
    check("sat_reach_max", 32'(true_count), 32'd255);
    drive(t1);
    cycle();
    in_valid = 1'b0;
    drain("sat_extra_drain");
    check("sat_hold", 32'(true_count), 32'd255);

    drive(t1);
    cycle();
    in_valid = 1'b0;
    clear_count = 1'b1;
    cycle();
    clear_count = 1'b0;
    check("clear_priority", 32'(true_count), 32'd0);
    drain("clear_drain");
    check("clear_stays_zero", 32'(true_count), 32'd0);
    drive(t1);
    cycle();
    in_valid = 1'b0;
    drain("resume_drain");
    check("count_resumes", 32'(true_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
